mul_arbiter: RTL and testbench

- Shares one Booth multiplier (datapath plus its control unit) between NREQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Restarts the multiplier, waits for its Fin, and returns the product with a one-cycle done pulse.
- A watchdog aborts an operation whose Fin never arrives.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_arbiter_if.sv | 31 +++
 rtl/mul_arbiter_rr_picker.sv | 33 +++
 rtl/mul_arbiter.sv | 90 +++++++++
 tb/tb_mul_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier slice: state encoding, default
// operand width and an index-width helper.
package mul_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of an index into n entries; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester bus and multiplier link of the shared-multiplier arbiter.
interface mul_arbiter_if
    import mul_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] op_a;
    logic [NREQ*SIZE-1:0] op_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [2*SIZE-1:0]    result;
    logic                 busy;
    logic                 mul_start;
    logic [SIZE-1:0]      mul_a;
    logic [SIZE-1:0]      mul_b;
    logic                 mul_fin;
    logic [2*SIZE-1:0]    mul_p;

    modport slave (
        input  req, op_a, op_b, mul_fin, mul_p,
        output gnt, done, err, result, busy, mul_start, mul_a, mul_b
    );

    modport master (
        output req, op_a, op_b, mul_fin, mul_p,
        input  gnt, done, err, result, busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// wrapping modulo NREQ.
module rr_picker
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);
    logic found;
    int   j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one Booth multiplier between NREQ requesters,
// with a watchdog that aborts an operation whose Fin never comes.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int SIZE    = DEFAULT_SIZE,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2*SIZE + 4
) (
    input  logic          clk,
    input  logic          reset,
    mul_arbiter_if.slave  bus
);
    localparam int IW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick;
    logic [CW-1:0]   count;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req  (bus.req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            idx           <= '0;
            count         <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= 1'b0;
            bus.result    <= '0;
            bus.busy      <= 1'b0;
            bus.mul_start <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        idx           <= pick_idx;
                        bus.gnt       <= pick;
                        bus.mul_a     <= bus.op_a[pick_idx*SIZE +: SIZE];
                        bus.mul_b     <= bus.op_b[pick_idx*SIZE +: SIZE];
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= START;
                    end
                end
                // Fin seen here is left over from the previous operation.
                START: begin
                    bus.mul_start <= 1'b0;
                    count         <= '0;
                    state         <= RUN;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (bus.mul_fin) begin
                        bus.result <= bus.mul_p;
                        bus.done   <= bus.gnt;
                        state      <= DONE;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        bus.result <= '0;
                        bus.err    <= 1'b1;
                        bus.done   <= bus.gnt;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.gnt  <= '0;
                    bus.done <= '0;
                    bus.err  <= 1'b0;
                    bus.busy <= 1'b0;
                    ptr      <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed stimulus pushes expected completions,
// a monitor pops and compares them whenever the DUT starts or finishes an operation.
module tb_mul_arbiter;
    import mul_pkg::*;

    localparam int SIZE    = 4;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 2*SIZE + 4;
    localparam int NOM_LAT = SIZE + 4;
    localparam int TO_LAT  = TIMEOUT + 1;

    typedef struct {
        int                idx;
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [2*SIZE-1:0] res;
        logic              err;
        int                lat;
    } exp_t;

    exp_t q[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    mul_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int n_done    = 0;
    int cyc       = 0;
    int start_cyc = 0;

    // Multiplier model: Fin is held until the next restart, so a stale Fin is visible in START.
    logic              fin_en = 1'b1;
    logic              fin_q;
    logic [2*SIZE-1:0] p_q;
    int                mcnt;

    assign bus.mul_fin = fin_q;
    assign bus.mul_p   = p_q;

    always @(posedge clk) begin
        if (!reset) begin
            fin_q <= 1'b0;
            p_q   <= '0;
            mcnt  <= 0;
        end else if (bus.mul_start) begin
            fin_q <= 1'b0;
            mcnt  <= fin_en ? SIZE + 2 : 0;
            p_q   <= {{SIZE{bus.mul_a[SIZE-1]}}, bus.mul_a} * {{SIZE{bus.mul_b[SIZE-1]}}, bus.mul_b};
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) fin_q <= 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mul_start) begin
                if (q.size() == 0) begin
                    flag("unexpected_start");
                end else begin
                    check("start_gnt", 32'(bus.gnt), 32'(1) << q[0].idx);
                    check("start_mul_a", 32'(bus.mul_a), 32'(q[0].a));
                    check("start_mul_b", 32'(bus.mul_b), 32'(q[0].b));
                end
                start_cyc = cyc;
            end
            if (bus.done != '0) begin
                if (q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = q.pop_front();
                    check("done_onehot", 32'(bus.done), 32'(1) << e.idx);
                    check("done_gnt", 32'(bus.gnt), 32'(1) << e.idx);
                    check("done_result", 32'(bus.result), 32'(e.res));
                    check("done_err", 32'(bus.err), 32'(e.err));
                    check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
                end
                n_done++;
            end
        end
    end

    task automatic push(input int idx, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [2*SIZE-1:0] res, input logic err, input int lat);
        exp_t e;
        e.idx = idx; e.a = a; e.b = b; e.res = res; e.err = err; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        bus.op_a[i*SIZE +: SIZE] = a;
        bus.op_b[i*SIZE +: SIZE] = b;
    endtask

    task automatic wait_start(input string name);
        bit got = 1'b0;
        repeat (64) begin
            if (!got) begin
                @(negedge clk);
                got = bus.mul_start;
            end
        end
        if (!got) flag({name, "_start_timeout"});
    endtask

    task automatic wait_idle(input string name);
        bit got = 1'b0;
        repeat (200) begin
            if (!got) begin
                @(negedge clk);
                got = !bus.busy && (q.size() == 0);
            end
        end
        if (!got) flag({name, "_idle_timeout"});
    endtask

    task automatic wait_done_count(input int target, input string name);
        bit got = 1'b0;
        repeat (200) begin
            if (!got) begin
                @(negedge clk);
                got = (n_done >= target);
            end
        end
        if (!got) flag({name, "_done_timeout"});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       32'(bus.gnt),       32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_err"},       32'(bus.err),       32'd0);
        check({tag, "_result"},    32'(bus.result),    32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
        check({tag, "_mul_a"},     32'(bus.mul_a),     32'd0);
        check({tag, "_mul_b"},     32'(bus.mul_b),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Single request: 3 * 5 = 15
        set_op(0, 4'd3, 4'd5);
        push(0, 4'd3, 4'd5, 8'd15, 1'b0, NOM_LAT);
        bus.req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 32'(bus.gnt), 32'b0001);
        check("t1_busy", 32'(bus.busy), 32'd1);
        bus.req = '0;
        wait_idle("t1");

        // Contention from reset: grants 0,1,2,3,0
        reset   = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'(i + 2));
        @(negedge clk);
        reset = 1'b1;
        base  = n_done;
        push(0, 4'd1, 4'd2, 8'd2,  1'b0, NOM_LAT);
        push(1, 4'd2, 4'd3, 8'd6,  1'b0, NOM_LAT);
        push(2, 4'd3, 4'd4, 8'd12, 1'b0, NOM_LAT);
        push(3, 4'd4, 4'd5, 8'd20, 1'b0, NOM_LAT);
        push(0, 4'd1, 4'd2, 8'd2,  1'b0, NOM_LAT);
        wait_done_count(base + 4, "t2");
        wait_start("t2_wrap");
        bus.req = '0;
        wait_idle("t2");

        // Signed product: -3 * 2 = -6
        set_op(1, 4'b1101, 4'd2);
        push(1, 4'b1101, 4'd2, 8'hFA, 1'b0, NOM_LAT);
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = '0;
        wait_idle("t3");

        // Timeout on requester 2, then requester 0 served normally: -2 * -3 = 6
        fin_en = 1'b0;
        set_op(2, 4'd7, 4'd7);
        set_op(0, 4'hE, 4'hD);
        push(2, 4'd7, 4'd7, 8'h00, 1'b1, TO_LAT);
        push(0, 4'hE, 4'hD, 8'h06, 1'b0, NOM_LAT);
        base    = n_done;
        bus.req = 4'b0101;
        wait_start("t4_timeout");
        bus.req = 4'b0001;
        wait_done_count(base + 1, "t4");
        fin_en = 1'b1;
        wait_start("t4_next");
        bus.req = '0;
        wait_idle("t4");

        // Operand freeze: 6 * 5 = 30 despite op/req changes during RUN
        set_op(0, 4'd6, 4'd5);
        push(0, 4'd6, 4'd5, 8'h1E, 1'b0, NOM_LAT);
        bus.req = 4'b0001;
        wait_start("t5");
        repeat (2) @(negedge clk);
        set_op(0, 4'd1, 4'd1);
        bus.req = '0;
        @(negedge clk);
        check("t5_mul_a_frozen", 32'(bus.mul_a), 32'd6);
        check("t5_mul_b_frozen", 32'(bus.mul_b), 32'd5);
        check("t5_gnt_held", 32'(bus.gnt), 32'b0001);
        wait_idle("t5");

        // Leave ptr at 3: 2 * -1 = -2
        set_op(2, 4'd2, 4'hF);
        push(2, 4'd2, 4'hF, 8'hFE, 1'b0, NOM_LAT);
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = '0;
        wait_idle("t6");

        // Reset mid-RUN: no done, outputs cleared, ptr back to 0
        set_op(3, 4'd5, 4'd5);
        push(3, 4'd5, 4'd5, 8'd25, 1'b0, NOM_LAT);
        bus.req = 4'b1000;
        wait_start("t7_abort");
        bus.req = '0;
        repeat (2) @(negedge clk);
        q.delete();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all_zero("t7_abort");
        set_op(2, 4'h8, 4'h8);
        push(2, 4'h8, 4'h8, 8'h40, 1'b0, NOM_LAT);
        push(3, 4'd5, 4'd5, 8'h19, 1'b0, NOM_LAT);
        bus.req = 4'b1100;
        @(negedge clk);
        check("t7_gnt_after_reset", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b1000;
        wait_start("t7_second");
        bus.req = '0;
        wait_idle("t7");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
